hp_round: RTL and testbench

Pipelined rounding stage for half-precision results. It sits directly downstream of the half-precision multiplier, consumes its truncated `result`, extended mantissa `round_mant` and class flags, and applies one of three rounding modes: round-to-nearest-even, stochastic, or truncate. Stochastic rounding draws its random bits from an internal seedable 16-bit LFSR. It produces the final rounded half-precision value and updated class flags through a valid/ready pipeline.

---
 rtl/hp_round.sv | 161 ++++++++++++++++
 tb/tb_hp_round.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_round.sv
// Two-stage fp16 rounding stage: RNE, stochastic (LFSR-driven) or truncate,
// with class flags recomputed after the magnitude increment.
module hp_round #(
  parameter int unsigned num_round_bits = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [15:0]                 in_result,
  input  logic [9+num_round_bits:0]   in_round_mant,
  input  logic                        in_zero,
  input  logic                        in_inf,
  input  logic                        in_subN,
  input  logic                        in_Norm,
  input  logic                        in_QNan,
  input  logic                        in_SNan,
  input  logic [1:0]                  rnd_mode,
  input  logic                        seed_load,
  input  logic [15:0]                 seed,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 out_result,
  output logic                        out_zero,
  output logic                        out_inf,
  output logic                        out_subN,
  output logic                        out_Norm,
  output logic                        out_QNan,
  output logic                        out_SNan,
  output logic                        out_inexact
);
  localparam int unsigned R = num_round_bits;
  // Selects rb[R-2:0]; empty when R = 1 so the sticky bit is then 0.
  localparam logic [R-1:0] LOW_MASK = R'((32'd1 << (R - 1)) - 32'd1);
  localparam logic [15:0]  LFSR_INIT = 16'hACE1;

  // Class vector bit order: {zero, inf, subN, Norm, QNan, SNan}
  localparam logic [5:0] CLS_INF  = 6'b010000;
  localparam logic [5:0] CLS_SUBN = 6'b001000;
  localparam logic [5:0] CLS_NORM = 6'b000100;

  typedef enum logic [1:0] {
    MODE_RNE     = 2'b00,
    MODE_SR      = 2'b01,
    MODE_RTZ     = 2'b10,
    MODE_RTZ_ALT = 2'b11
  } rnd_mode_e;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic        accept;
  logic        s1_advance;
  logic        s2_advance;

  logic        s1_valid;
  logic [15:0] s1_result;
  logic [R-1:0] s1_rb;
  logic [R-1:0] s1_r;
  logic [5:0]  s1_cls;
  rnd_mode_e   s1_mode;

  logic [5:0]  in_cls;
  logic [5:0]  out_cls;

  logic        round_en;
  logic        g_bit;
  logic        s_bit;
  logic [R:0]  sr_sum;
  logic        inc;
  logic [14:0] mag;
  logic [15:0] nxt_result;
  logic [5:0]  nxt_cls;
  logic        nxt_inexact;

  logic        unused_mant_hi;

  assign in_cls = {in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan};
  assign {out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan} = out_cls;
  // Upper round_mant bits duplicate in_result[9:0]; the fraction is taken from in_result.
  assign unused_mant_hi = ^in_round_mant[9+R:R];

  assign s2_advance = !out_valid | out_ready;
  assign s1_advance = !s1_valid | s2_advance;
  assign in_ready   = s1_advance;
  assign accept     = in_valid & s1_advance;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= LFSR_INIT;
    end else if (seed_load) begin
      lfsr <= (seed == 16'd0) ? LFSR_INIT : seed;
    end else if (accept) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_result <= '0;
      s1_rb     <= '0;
      s1_r      <= '0;
      s1_cls    <= '0;
      s1_mode   <= MODE_RNE;
    end else if (s1_advance) begin
      s1_valid  <= in_valid;
      s1_result <= in_result;
      s1_rb     <= in_round_mant[R-1:0];
      s1_r      <= lfsr[R-1:0];
      s1_cls    <= in_cls;
      s1_mode   <= rnd_mode_e'(rnd_mode);
    end
  end

  always_comb begin
    round_en = (s1_cls == CLS_NORM) | (s1_cls == CLS_SUBN);
    g_bit    = s1_rb[R-1];
    s_bit    = |(s1_rb & LOW_MASK);
    sr_sum   = {1'b0, s1_rb} + {1'b0, s1_r};
    inc      = 1'b0;
    if (round_en) begin
      case (s1_mode)
        MODE_RNE:     inc = g_bit & (s_bit | s1_result[0]);
        MODE_SR:      inc = sr_sum[R];
        MODE_RTZ:     inc = 1'b0;
        MODE_RTZ_ALT: inc = 1'b0;
        default:      inc = 1'b0;
      endcase
    end
    // Carry out of the fraction lands in the exponent, giving subN->Norm and max->Inf.
    mag         = s1_result[14:0] + {14'd0, inc};
    nxt_result  = {s1_result[15], mag};
    nxt_cls     = s1_cls;
    nxt_inexact = 1'b0;
    if (round_en) begin
      nxt_inexact = |s1_rb;
      if (&mag[14:10])            nxt_cls = CLS_INF;
      else if (mag[14:10] == 5'd0) nxt_cls = CLS_SUBN;
      else                         nxt_cls = CLS_NORM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_cls     <= '0;
      out_inexact <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= nxt_result;
        out_cls     <= nxt_cls;
        out_inexact <= nxt_inexact;
      end
    end
  end

endmodule

// File: tb/tb_hp_round.sv
// Randomized and directed bench for hp_round against an arithmetic reference model.
module tb_hp_round;
  localparam int unsigned R = 4;

  localparam logic [5:0] C_ZERO = 6'b100000;
  localparam logic [5:0] C_INF  = 6'b010000;
  localparam logic [5:0] C_SUBN = 6'b001000;
  localparam logic [5:0] C_NORM = 6'b000100;
  localparam logic [5:0] C_QNAN = 6'b000010;
  localparam logic [5:0] C_SNAN = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, seed_load, out_valid, out_ready, out_inexact;
  logic [15:0]  in_result, seed, out_result;
  logic [R-1:0] in_rb;
  logic [9+R:0] in_round_mant;
  logic [5:0]   in_cls, out_cls;
  logic [1:0]   rnd_mode;
  logic in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan;
  logic out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan;

  assign in_round_mant = {in_result[9:0], in_rb};
  assign {in_zero, in_inf, in_subN, in_Norm, in_QNan, in_SNan} = in_cls;
  assign out_cls = {out_zero, out_inf, out_subN, out_Norm, out_QNan, out_SNan};

  hp_round #(.num_round_bits(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_round_mant(in_round_mant),
    .in_zero(in_zero), .in_inf(in_inf), .in_subN(in_subN),
    .in_Norm(in_Norm), .in_QNan(in_QNan), .in_SNan(in_SNan),
    .rnd_mode(rnd_mode), .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_inf(out_inf), .out_subN(out_subN),
    .out_Norm(out_Norm), .out_QNan(out_QNan), .out_SNan(out_SNan),
    .out_inexact(out_inexact)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] res;
    logic [5:0]  cls;
    logic        inx;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    int v, fb;
    v  = int'(l);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return 16'(((v << 1) | fb) & 32'hFFFF);
  endfunction

  function automatic exp_t model(input logic [15:0] res, input logic [R-1:0] rb,
                                 input logic [5:0] cls, input logic [1:0] mode,
                                 input logic [15:0] lf);
    exp_t e;
    int rbv, rv, inc, mag, ex, half;
    rbv  = int'(rb);
    rv   = int'(lf) % (1 << R);
    half = 1 << (R - 1);
    e.res = res; e.cls = cls; e.inx = 1'b0; e.acc_cyc = 0;
    if (cls == C_NORM || cls == C_SUBN) begin
      inc = 0;
      if (mode == 2'd0)
        inc = (rbv > half || (rbv == half && res[0] == 1'b1)) ? 1 : 0;
      else if (mode == 2'd1)
        inc = (rbv + rv >= (1 << R)) ? 1 : 0;
      mag   = int'(res[14:0]) + inc;
      e.res = {res[15], 15'(mag)};
      ex    = mag / 1024;
      e.cls = (ex == 31) ? C_INF : (ex == 0) ? C_SUBN : C_NORM;
      e.inx = (rbv != 0);
    end
    return e;
  endfunction

  int          cyc = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          out_count = 0;
  logic [15:0] last_res;
  logic [5:0]  last_cls;
  logic        last_inx;
  int          last_lat = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_lfsr = 16'hACE1;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_val("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check_val("out_result", out_result, e.res);
          check_val("out_class", out_cls, e.cls);
          check_val("out_inexact", out_inexact, e.inx);
          last_lat = cyc - e.acc_cyc;
        end
        last_res = out_result;
        last_cls = out_cls;
        last_inx = out_inexact;
        out_count++;
      end
      if (in_valid && in_ready) begin
        e = model(in_result, in_rb, in_cls, rnd_mode, m_lfsr);
        e.acc_cyc = cyc;
        q.push_back(e);
      end
      if (seed_load) m_lfsr = (seed == 16'd0) ? 16'hACE1 : seed;
      else if (in_valid && in_ready) m_lfsr = lfsr_step(m_lfsr);
    end
  end

  function automatic logic [15:0] rand_norm();
    logic [4:0] e;
    logic [9:0] f;
    e = 5'(1 + $urandom % 30);
    f = ($urandom % 4 == 0) ? 10'h3FF : 10'($urandom);
    return {1'($urandom), e, f};
  endfunction

  task automatic rand_item();
    int k;
    logic s;
    logic [9:0] f;
    k = int'($urandom % 8);
    s = 1'($urandom);
    f = 10'($urandom);
    in_rb = R'($urandom);
    case (k)
      0: begin in_cls = C_ZERO; in_result = {s, 15'd0}; end
      1: begin in_cls = C_INF;  in_result = {s, 5'h1F, 10'd0}; end
      2: begin in_cls = C_QNAN; in_result = {s, 5'h1F, 1'b1, f[8:0]}; end
      3: begin in_cls = C_SNAN; in_result = {s, 5'h1F, 1'b0, (f[8:0] == 9'd0) ? 9'd1 : f[8:0]}; end
      4: begin in_cls = C_SUBN; in_result = {s, 5'd0, (f == 10'd0) ? 10'd1 : f}; end
      default: begin in_cls = C_NORM; in_result = rand_norm(); end
    endcase
  endtask

  task automatic send(input logic [15:0] res, input logic [R-1:0] rb,
                      input logic [5:0] cls, input logic [1:0] mode);
    int k;
    in_result = res; in_rb = rb; in_cls = cls; rnd_mode = mode; in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    if (!in_ready) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int c0);
    int k;
    k = 0;
    while (out_count == c0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    if (out_count == c0) check_val("out_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic run_one(input logic [15:0] res, input logic [R-1:0] rb,
                         input logic [5:0] cls, input logic [1:0] mode);
    int c0;
    c0 = out_count;
    send(res, rb, cls, mode);
    wait_out(c0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, idx, acc_low, k;
    logic [15:0] held;
    logic held_set;
    logic [15:0] bp_res[8];

    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_rb = '0; in_cls = C_ZERO;
    rnd_mode = 2'd0; seed_load = 1'b0; seed = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 32'd0);
    check_val("rst_out_result", out_result, 32'd0);
    check_val("rst_out_class", out_cls, 32'd0);
    check_val("rst_out_inexact", out_inexact, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_one(16'h3C00, 4'b1000, C_NORM, 2'd0);
    check_val("rne_tie_even", last_res, 16'h3C00);
    check_val("rne_tie_even_cls", last_cls, C_NORM);
    check_val("rne_tie_even_inx", last_inx, 32'd1);
    check_val("latency", last_lat, 32'd2);
    run_one(16'h3C01, 4'b1000, C_NORM, 2'd0);
    check_val("rne_tie_odd", last_res, 16'h3C02);
    run_one(16'h3C00, 4'b1001, C_NORM, 2'd0);
    check_val("rne_above_half", last_res, 16'h3C01);

    run_one(16'h7BFF, 4'b1100, C_NORM, 2'd0);
    check_val("carry_to_inf", last_res, 16'h7C00);
    check_val("carry_to_inf_cls", last_cls, C_INF);
    run_one(16'h03FF, 4'b1000, C_SUBN, 2'd0);
    check_val("subn_to_norm", last_res, 16'h0400);
    check_val("subn_to_norm_cls", last_cls, C_NORM);
    run_one(16'h83FF, 4'b1000, C_SUBN, 2'd0);
    check_val("neg_carry", last_res, 16'h8400);

    reset_dut();
    run_one(16'h3C00, 4'hD, C_NORM, 2'd1);
    check_val("sr_first", last_res, 16'h3C00);
    run_one(16'h3C00, 4'hD, C_NORM, 2'd1);
    check_val("sr_second", last_res, 16'h3C01);

    // rb = 0 under SR: the model expects no increment on any sample
    out_ready = 1'b1; rnd_mode = 2'd1; in_rb = '0; in_cls = C_NORM; in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_result = rand_norm();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int m = 0; m < 4; m++) begin
      run_one(16'h7E00, 4'hF, C_QNAN, 2'(m));
      check_val("qnan_pass", last_res, 16'h7E00);
      check_val("qnan_pass_cls", last_cls, C_QNAN);
      check_val("qnan_pass_inx", last_inx, 32'd0);
      run_one(16'hFC00, 4'hF, C_INF, 2'(m));
      check_val("inf_pass", last_res, 16'hFC00);
      check_val("inf_pass_cls", last_cls, C_INF);
      check_val("inf_pass_inx", last_inx, 32'd0);
    end
    run_one(16'h3C05, 4'hF, C_NORM, 2'd2);
    check_val("rtz_norm", last_res, 16'h3C05);
    check_val("rtz_norm_inx", last_inx, 32'd1);
    run_one(16'h3C05, 4'hF, C_NORM, 2'd3);
    check_val("rtz_alt_norm", last_res, 16'h3C05);

    // Backpressure: 8 transactions, consumer stalled for 5 cycles
    for (int i = 0; i < 8; i++) bp_res[i] = rand_norm();
    c0 = out_count; idx = 0; acc_low = 0; held = '0; held_set = 1'b0;
    out_ready = 1'b0; rnd_mode = 2'd0; in_cls = C_NORM; in_rb = R'($urandom);
    in_result = bp_res[0]; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!held_set) begin held = out_result; held_set = 1'b1; end
        else check_val("bp_hold", out_result, held);
      end
      if (in_ready) begin acc_low++; idx++; end
      @(posedge clk); #1;
      if (idx < 8) begin in_result = bp_res[idx]; in_rb = R'($urandom); end
      else in_valid = 1'b0;
    end
    check_val("bp_accepts_stalled", acc_low, 32'd2);
    check_val("bp_out_valid_held", out_valid, 32'd1);
    out_ready = 1'b1;
    k = 0;
    while (idx < 8 && k < 50) begin
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 8) begin in_result = bp_res[idx]; in_rb = R'($urandom); end
      else in_valid = 1'b0;
      k++;
    end
    in_valid = 1'b0;
    k = 0;
    while (out_count - c0 < 8 && k < 30) begin @(posedge clk); k++; end
    #1;
    check_val("bp_count", out_count - c0, 32'd8);

    // Seed 0 must load 0xACE1 (r = 1), so rb = 0xF rounds up
    seed_load = 1'b1; seed = 16'h1230;
    @(posedge clk); #1;
    seed = 16'h0000;
    @(posedge clk); #1;
    seed_load = 1'b0;
    run_one(16'h3C00, 4'hF, C_NORM, 2'd1);
    check_val("seed_zero", last_res, 16'h3C01);

    // Reset with two transactions in flight
    out_ready = 1'b0;
    c0 = out_count;
    send(rand_norm(), 4'h9, C_NORM, 2'd0);
    send(rand_norm(), 4'h3, C_NORM, 2'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_out_valid", out_valid, 32'd0);
    check_val("midrst_out_result", out_result, 32'd0);
    check_val("midrst_out_class", out_cls, 32'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("midrst_dropped", out_count - c0, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      rand_item();
      in_valid  = ($urandom % 4) != 0;
      rnd_mode  = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      seed_load = ($urandom % 16) == 0;
      seed      = ($urandom % 4 == 0) ? 16'd0 : 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("drain_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
